// File: rtl/gpu_frame_sequencer.sv
// gpu_frame_sequencer: frame-level controller for multi-buffered rendering.
// Each frame: pulse matrix_latch, pulse gpu_start, wait for the GPU frame end,
// wait for display vsync, then rotate render/display framebuffer indices.
// Pulse outputs (matrix_latch, gpu_start) are single-cycle, registered, and
// carry no handshake: the consumer must act on the cycle they are high.
module gpu_frame_sequencer #(
    parameter int NUM_BUFFERS    = 2,
    parameter int ADDR_W         = 32,
    parameter int FB_STRIDE      = 480000,
    parameter int TIMEOUT_CYCLES = 16777216
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] fb_base,
    input  logic              run,
    input  logic              single_shot,
    input  logic              err_clear,
    input  logic              gpu_frame_end,
    input  logic              display_vsync,
    output logic              matrix_latch,
    output logic              gpu_start,
    output logic [ADDR_W-1:0] render_baseaddr,
    output logic [ADDR_W-1:0] display_baseaddr,
    output logic              busy,
    output logic [15:0]       frame_count,
    output logic              timeout_err,
    output logic [2:0]        state_dbg
);

    localparam int IDX_W = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_W-1:0] STRIDE_A    = ADDR_W'(FB_STRIDE);
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NUM_BUFFERS - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LATCH     = 3'd1,
        S_START     = 3'd2,
        S_RENDER    = 3'd3,
        S_WAIT_FLIP = 3'd4,
        S_FLIP      = 3'd5
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   render_idx_q;
    logic [IDX_W-1:0]   display_idx_q;
    logic [IDX_W-1:0]   render_idx_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               frame_end_q;
    logic               oneshot_q;
    logic               matrix_latch_q;
    logic               gpu_start_q;
    logic               busy_q;
    logic               timeout_err_q;
    logic [15:0]        frame_count_q;
    logic               frame_end_edge;

    // Rising-edge detect on gpu_frame_end; a level already high on RENDER entry is not an edge.
    assign frame_end_edge = gpu_frame_end & ~frame_end_q;

    // Next render buffer in the rotation.
    assign render_idx_d = (render_idx_q == LAST_IDX) ? '0 : render_idx_q + 1'b1;

    // Base addresses follow the registered indices; product truncates to ADDR_W.
    assign render_baseaddr  = fb_base + ADDR_W'(render_idx_q) * STRIDE_A;
    assign display_baseaddr = fb_base + ADDR_W'(display_idx_q) * STRIDE_A;

    assign matrix_latch = matrix_latch_q;
    assign gpu_start    = gpu_start_q;
    assign busy         = busy_q;
    assign frame_count  = frame_count_q;
    assign timeout_err  = timeout_err_q;
    assign state_dbg    = state_q;

    // Frame sequencing FSM with registered pulse/status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            render_idx_q   <= IDX_W'(1);
            display_idx_q  <= '0;
            cnt_q          <= '0;
            frame_end_q    <= 1'b0;
            oneshot_q      <= 1'b0;
            matrix_latch_q <= 1'b0;
            gpu_start_q    <= 1'b0;
            busy_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
            frame_count_q  <= '0;
        end else begin
            frame_end_q    <= gpu_frame_end;
            matrix_latch_q <= 1'b0;
            gpu_start_q    <= 1'b0;
            // A timeout raised below in the same cycle overrides this clear.
            if (err_clear) begin
                timeout_err_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if ((run || single_shot) && !timeout_err_q) begin
                        oneshot_q      <= single_shot & ~run;
                        matrix_latch_q <= 1'b1;
                        busy_q         <= 1'b1;
                        state_q        <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    gpu_start_q <= 1'b1;
                    state_q     <= S_START;
                end
                S_START: begin
                    cnt_q   <= '0;
                    state_q <= S_RENDER;
                end
                S_RENDER: begin
                    if (frame_end_edge) begin
                        state_q <= display_vsync ? S_FLIP : S_WAIT_FLIP;
                    end else if (cnt_q == TIMEOUT_MAX) begin
                        timeout_err_q <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_WAIT_FLIP: begin
                    if (display_vsync) begin
                        state_q <= S_FLIP;
                    end
                end
                S_FLIP: begin
                    display_idx_q <= render_idx_q;
                    render_idx_q  <= render_idx_d;
                    frame_count_q <= frame_count_q + 16'd1;
                    if (oneshot_q || !run) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        matrix_latch_q <= 1'b1;
                        state_q        <= S_LATCH;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_frame_sequencer.sv
// Directed bench for gpu_frame_sequencer (3 buffers, short timeout).
// Flip results are predicted by a small index model and queued; a monitor
// pops and compares whenever the address/frame_count tuple changes.
module tb_gpu_frame_sequencer;

    localparam int NB     = 3;
    localparam int AW     = 32;
    localparam int STRIDE = 480000;
    localparam int TO     = 100;
    localparam logic [AW-1:0] BASE = 32'h1000_0000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] fb_base = BASE;
    logic          run = 1'b0;
    logic          single_shot = 1'b0;
    logic          err_clear = 1'b0;
    logic          gpu_frame_end = 1'b0;
    logic          display_vsync = 1'b0;
    logic          matrix_latch;
    logic          gpu_start;
    logic [AW-1:0] render_baseaddr;
    logic [AW-1:0] display_baseaddr;
    logic          busy;
    logic [15:0]   frame_count;
    logic          timeout_err;
    logic [2:0]    state_dbg;

    int tests = 0;
    int fails = 0;
    logic [79:0] exp_q[$];
    logic [79:0] mon_cur;
    logic [79:0] mon_prev;
    logic        mon_en = 1'b0;
    int m_d  = 0;
    int m_r  = 1;
    int m_fc = 0;

    gpu_frame_sequencer #(
        .NUM_BUFFERS(NB), .ADDR_W(AW), .FB_STRIDE(STRIDE), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .fb_base(fb_base), .run(run),
        .single_shot(single_shot), .err_clear(err_clear),
        .gpu_frame_end(gpu_frame_end), .display_vsync(display_vsync),
        .matrix_latch(matrix_latch), .gpu_start(gpu_start),
        .render_baseaddr(render_baseaddr), .display_baseaddr(display_baseaddr),
        .busy(busy), .frame_count(frame_count), .timeout_err(timeout_err),
        .state_dbg(state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [AW-1:0] addr(input int i);
        return BASE + AW'(i * STRIDE);
    endfunction

    function automatic logic [79:0] tup(input int d, input int r, input int fc);
        return {addr(d), addr(r), 16'(fc)};
    endfunction

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int n);
        repeat (n) tick();
    endtask

    // Model of one flip: new display = old render, render advances.
    task automatic push_flip();
        m_d = m_r;
        m_r = (m_r + 1) % NB;
        m_fc++;
        exp_q.push_back(tup(m_d, m_r, m_fc));
    endtask

    task automatic push_reset();
        m_d = 0;
        m_r = 1;
        m_fc = 0;
        exp_q.push_back(tup(m_d, m_r, m_fc));
    endtask

    // Ticks until gpu_start is seen or the budget runs out.
    task automatic wait_gs(input int budget, output int n);
        n = 0;
        while (gpu_start !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
    endtask

    // Scoreboard monitor: any change of {display, render, frame_count} must match the queue head.
    always @(negedge clk) begin
        mon_cur = {display_baseaddr, render_baseaddr, frame_count};
        if (mon_en && mon_cur !== mon_prev) begin
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL sb_unexpected: got %0h, expected no update", mon_cur);
            end
            if (exp_q.size() != 0) check("sb_flip", mon_cur, exp_q.pop_front());
        end
        mon_prev = mon_cur;
    end

    initial begin
        int n;
        logic seen;

        // Reset state
        step(2);
        reset = 1'b0;
        check("rst_display", display_baseaddr, 32'h1000_0000);
        check("rst_render", render_baseaddr, 32'h1007_5300);
        check("rst_busy", busy, 0);
        check("rst_latch", matrix_latch, 0);
        check("rst_start", gpu_start, 0);
        check("rst_count", frame_count, 0);
        check("rst_err", timeout_err, 0);
        mon_en = 1'b1;

        // Single shot
        single_shot = 1'b1;
        tick();
        single_shot = 1'b0;
        check("ss_latch_t1", {matrix_latch, gpu_start, busy}, 3'b101);
        tick();
        check("ss_start_t2", {matrix_latch, gpu_start}, 2'b01);
        step(50);
        gpu_frame_end = 1'b1;
        tick();
        gpu_frame_end = 1'b0;
        step(9);
        display_vsync = 1'b1;
        push_flip();
        tick();
        display_vsync = 1'b0;
        check("ss_disp_v1", display_baseaddr, addr(0));
        tick();
        check("ss_disp_v2", display_baseaddr, addr(1));
        check("ss_rend_v2", render_baseaddr, addr(2));
        check("ss_count", frame_count, 1);
        check("ss_busy", busy, 0);

        // Continuous run, 3 frames, from fresh reset
        reset = 1'b1;
        push_reset();
        tick();
        reset = 1'b0;
        tick();
        run = 1'b1;
        wait_gs(10, n);
        check("run_gs_lat0", n, 2);
        for (int f = 0; f < 3; f++) begin
            check("run_rend_at_start", render_baseaddr, addr(m_r));
            check("run_disp_at_start", display_baseaddr, addr(m_d));
            if (f == 0) begin
                step(20);
                gpu_frame_end = 1'b1;
                tick();
                gpu_frame_end = 1'b0;
                step(4);
                display_vsync = 1'b1;
                push_flip();
                tick();
                display_vsync = 1'b0;
                wait_gs(10, n);
                check("run_gs_after_flip", n, 2);
            end else if (f == 1) begin
                step(20);
                gpu_frame_end = 1'b1;
                display_vsync = 1'b1;
                push_flip();
                tick();
                gpu_frame_end = 1'b0;
                display_vsync = 1'b0;
                wait_gs(10, n);
                check("run_gs_simul", n, 2);
            end else begin
                step(5);
                run = 1'b0;
                step(15);
                gpu_frame_end = 1'b1;
                tick();
                gpu_frame_end = 1'b0;
                step(3);
                display_vsync = 1'b1;
                push_flip();
                tick();
                display_vsync = 1'b0;
                tick();
                check("drop_busy", busy, 0);
                check("drop_count", frame_count, 3);
                seen = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    tick();
                    if (matrix_latch === 1'b1 || gpu_start === 1'b1) seen = 1'b1;
                end
                check("drop_no_restart", seen, 0);
            end
        end

        // Timeout, err_clear colliding with the timeout cycle
        run = 1'b1;
        tick();
        check("to_latch", matrix_latch, 1);
        tick();
        check("to_start", gpu_start, 1);
        step(100);
        err_clear = 1'b1;
        check("to_err_before", timeout_err, 0);
        tick();
        err_clear = 1'b0;
        check("to_err_set", timeout_err, 1);
        check("to_busy", busy, 0);
        check("to_addrs", {display_baseaddr, render_baseaddr}, {addr(m_d), addr(m_r)});
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (matrix_latch === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        check("to_blocks_run", seen, 0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("clr_err", timeout_err, 0);
        tick();
        check("clr_latch", matrix_latch, 1);
        tick();
        check("clr_start", gpu_start, 1);
        run = 1'b0;
        step(10);
        gpu_frame_end = 1'b1;
        tick();
        gpu_frame_end = 1'b0;
        step(2);
        display_vsync = 1'b1;
        push_flip();
        tick();
        display_vsync = 1'b0;
        tick();
        check("clr_busy", busy, 0);

        // frame_end held high across START must not end RENDER
        gpu_frame_end = 1'b1;
        tick();
        single_shot = 1'b1;
        tick();
        single_shot = 1'b0;
        tick();
        check("hold_start", gpu_start, 1);
        step(5);
        display_vsync = 1'b1;
        tick();
        display_vsync = 1'b0;
        step(5);
        check("hold_busy", busy, 1);
        check("hold_count", frame_count, m_fc);
        gpu_frame_end = 1'b0;
        tick();
        gpu_frame_end = 1'b1;
        tick();
        gpu_frame_end = 1'b0;
        step(2);
        display_vsync = 1'b1;
        push_flip();
        tick();
        display_vsync = 1'b0;
        tick();
        check("hold_disp", display_baseaddr, addr(m_d));
        check("hold_done", busy, 0);

        // Reset in WAIT_FLIP with a coincident vsync: no flip
        single_shot = 1'b1;
        tick();
        single_shot = 1'b0;
        tick();
        check("wrst_render_at_start", render_baseaddr, addr(m_r));
        step(8);
        gpu_frame_end = 1'b1;
        tick();
        gpu_frame_end = 1'b0;
        step(3);
        reset = 1'b1;
        display_vsync = 1'b1;
        push_reset();
        tick();
        reset = 1'b0;
        display_vsync = 1'b0;
        check("wrst_state", {busy, matrix_latch, gpu_start, timeout_err}, 4'b0000);
        check("wrst_addrs", {display_baseaddr, render_baseaddr, frame_count}, tup(0, 1, 0));
        step(3);
        check("wrst_no_flip", {display_baseaddr, frame_count}, {addr(0), 16'd0});

        step(2);
        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gpu_frame_sequencer.md
Name: gpu_frame_sequencer

Overview:
- Frame-level controller that sequences GPU_top and the AXI framebuffer writer for double/multi-buffered rendering.
- Per frame, in order:
  - pulses a transform-matrix latch so the shadow matrix becomes live;
  - pulses GPU start;
  - waits for frame end;
  - waits for the display vsync;
  - flips the render and display framebuffer base addresses.
- Sits between the PS-side config registers and the GPU_top / axi_master_burst_axi3 pair. Supplies framebuffer_baseaddr to the writer and the scanout base to the display controller.

Parameters:
- NUM_BUFFERS, 2, number of framebuffers in rotation (2..4).
- ADDR_W, 32, address width.
- FB_STRIDE, 480000, byte distance between consecutive framebuffers (800*600*1 B).
- TIMEOUT_CYCLES, 16777216, max RENDER cycles before abort.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- fb_base  in  ADDR_W  byte address of buffer 0
- run  in  1  level: render frames continuously while high
- single_shot  in  1  pulse: render exactly one frame
- err_clear  in  1  pulse: clears timeout_err
- gpu_frame_end  in  1  GPU_top frame_end (level or pulse; edge-detected internally)
- display_vsync  in  1  one-cycle pulse from display controller
- matrix_latch  out  1  one-cycle pulse: copy shadow transform_matrix to live
- gpu_start  out  1  one-cycle pulse to GPU_top start
- render_baseaddr  out  ADDR_W  fb_base + render_idx*FB_STRIDE (to framebuffer_baseaddr)
- display_baseaddr  out  ADDR_W  fb_base + display_idx*FB_STRIDE
- busy  out  1  high in any state other than IDLE
- frame_count  out  16  frames completed and flipped (wraps 65535->0)
- timeout_err  out  1  sticky render timeout flag

Behaviour:
- Reset values:
  - state=IDLE; display_idx=0; render_idx=1.
  - matrix_latch=0, gpu_start=0, busy=0, frame_count=0, timeout_err=0.
  - Timeout counter=0; frame_end edge register=0; pending single-shot=0.
- Base addresses are combinational from fb_base and the registered indices. Multiply by constant FB_STRIDE; result truncated to ADDR_W.
- States:
  - IDLE:
    - If (run | single_shot) and !timeout_err -> LATCH.
    - Set oneshot flag = single_shot & !run.
  - LATCH: matrix_latch=1 for this cycle -> START.
  - START: gpu_start=1 for this cycle; clear timeout counter -> RENDER.
  - RENDER:
    - Count cycles.
    - On rising edge of gpu_frame_end: if display_vsync is high the same cycle -> FLIP, else -> WAIT_FLIP.
    - If the counter reaches TIMEOUT_CYCLES-1 with no edge: set timeout_err; no flip; no frame_count increment -> IDLE.
  - WAIT_FLIP: on display_vsync -> FLIP.
  - FLIP (one cycle):
    - display_idx <= render_idx; render_idx <= (render_idx+1) mod NUM_BUFFERS.
    - frame_count++.
    - Then: IDLE if oneshot or !run; LATCH if run (back-to-back frames).
- Latency:
  - run first seen high in IDLE at cycle T -> matrix_latch at T+1, gpu_start at T+2.
  - Flip: display_vsync at cycle V in WAIT_FLIP -> new addresses visible at V+2. FLIP is at V+1; indices update at the end of that cycle.
- Frame end:
  - A gpu_frame_end already high when entering RENDER is not an edge. The edge register samples every cycle, including in START.
  - Edges outside RENDER are ignored.
- Deasserting run mid-frame does not abort. The current frame completes and flips, then -> IDLE.
- single_shot while busy is ignored. single_shot and run together = run.
- timeout_err blocks new frames until err_clear. err_clear in the same cycle as a timeout: set wins.
- render_baseaddr is stable from START through FLIP. It never changes while the GPU is writing.
- Reset mid-operation: return to the reset values on the next edge. No pulses are emitted in the reset cycle.

Test Plan:
- Reset → check reset state, then addresses. fb_base=0x1000_0000, reset → display_baseaddr=0x1000_0000, render_baseaddr=0x1007_5300, busy=0, all pulses 0.
- Single shot:
  - Stimulus: single_shot pulse at T; frame_end pulse 50 cycles after gpu_start; vsync 10 cycles later.
  - Required: matrix_latch at T+1, gpu_start at T+2; addresses swap 2 cycles after vsync; frame_count=1; busy=0 after FLIP.
- Continuous run, 3 frames, NUM_BUFFERS=3:
  - render_baseaddr sequence: 1*FB_STRIDE, 2*FB_STRIDE, 0.
  - display_baseaddr sequence: 0, 1*FB_STRIDE, 2*FB_STRIDE.
  - gpu_start for the next frame arrives 2 cycles after FLIP.
- Simultaneous events: frame_end edge in the same cycle as vsync → FLIP next cycle, no WAIT_FLIP. frame_end held high across START → no premature RENDER exit.
- Timeout: TIMEOUT_CYCLES=100 with frame_end never asserted → timeout_err=1 at 100 cycles after RENDER entry; addresses unchanged; run ignored until err_clear, then a new frame starts.
- Run dropped mid-RENDER: the frame still flips; frame_count increments once; next state is IDLE. Reset asserted in WAIT_FLIP → reset values next cycle, no flip.
